// File: rtl/core_mem_arbiter.sv
// Memory-port arbiter between instruction fetch and data access.
// Data has priority; fetch is forced after STARVE_LIMIT consecutive data grants. One transaction in flight.
module core_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rsp_data,
  input  logic                invalidate_fetch,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  typedef enum logic {OWN_D, OWN_I} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                drop_q, drop_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;

  logic grant_i, grant_d, rsp_fire;

  assign grant_i = i_req_valid & ~invalidate_fetch & ((starve_q == LIMIT) | ~d_req_valid);
  assign grant_d = ~grant_i & d_req_valid;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_i) begin
          i_req_ready = 1'b1;
          state_d     = ST_ISSUE;
          owner_d     = OWN_I;
          drop_d      = 1'b0;
          starve_d    = '0;
          addr_d      = i_req_addr;
          we_d        = 1'b0;
          wdata_d     = '0;
          wstrb_d     = '0;
        end else if (grant_d) begin
          d_req_ready = 1'b1;
          state_d     = ST_ISSUE;
          owner_d     = OWN_D;
          drop_d      = 1'b0;
          addr_d      = d_req_addr;
          we_d        = d_req_we;
          wdata_d     = d_req_wdata;
          wstrb_d     = d_req_wstrb;
          // Only count data wins that actually made a fetch wait.
          if (i_req_valid && (starve_q != LIMIT)) starve_d = starve_q + CNT_W'(1);
        end
      end
      ST_ISSUE: begin
        if ((owner_q == OWN_I) && invalidate_fetch) drop_d = 1'b1;
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if ((owner_q == OWN_I) && invalidate_fetch) drop_d = 1'b1;
        if (mem_rsp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_D;
      drop_q   <= 1'b0;
      starve_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      drop_q   <= drop_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

  assign rsp_fire      = (state_q == ST_WAIT) & mem_rsp_valid;
  assign d_rsp_valid   = rsp_fire & (owner_q == OWN_D);
  assign i_rsp_valid   = rsp_fire & (owner_q == OWN_I) & ~drop_q;
  assign d_rsp_data    = d_rsp_valid ? mem_rsp_data : '0;
  assign i_rsp_data    = i_rsp_valid ? mem_rsp_data : '0;
  assign mem_req_valid = (state_q == ST_ISSUE);
  assign mem_req_addr  = addr_q;
  assign mem_req_we    = we_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;
  assign busy          = (state_q != ST_IDLE);

  a_rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    mem_rsp_valid |-> (state_q == ST_WAIT));

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: grant table, directed multi-cycle sequences, and
// a randomized run against a transaction-level reference model.
module tb_core_mem_arbiter;
  localparam int AW = 32, DW = 32, SW = 4, LIM = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic          i_req_valid = 0, i_req_ready, i_rsp_valid, invalidate_fetch = 0;
  logic [AW-1:0] i_req_addr = '0;
  logic [DW-1:0] i_rsp_data;
  logic          d_req_valid = 0, d_req_ready, d_req_we = 0, d_rsp_valid;
  logic [AW-1:0] d_req_addr = '0;
  logic [DW-1:0] d_req_wdata = '0, d_rsp_data;
  logic [SW-1:0] d_req_wstrb = '0;
  logic          mem_req_valid, mem_req_ready = 0, mem_req_we, mem_rsp_valid = 0, busy;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_rsp_data = '0;
  logic [SW-1:0] mem_req_wstrb;

  int checks = 0;
  int failures = 0;

  core_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .invalidate_fetch(invalidate_fetch),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    i_req_valid = 0; i_req_addr = '0; invalidate_fetch = 0;
    d_req_valid = 0; d_req_addr = '0; d_req_we = 0; d_req_wdata = '0; d_req_wstrb = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
  endtask

  // Ends at posedge+1 with reset released and all inputs idle.
  task automatic do_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // From just after a grant: accept at once, respond one cycle later, check routing.
  task automatic serve_txn(input bit exp_i, input logic [DW-1:0] rdata);
    next_cycle();
    mem_req_ready = 1;
    next_cycle();
    mem_req_ready = 0;
    mem_rsp_valid = 1;
    mem_rsp_data  = rdata;
    @(negedge clk);
    chk("serve_i_rsp_valid", i_rsp_valid, exp_i);
    chk("serve_d_rsp_valid", d_rsp_valid, !exp_i);
    chk("serve_rsp_data", exp_i ? i_rsp_data : d_rsp_data, rdata);
    next_cycle();
    mem_rsp_valid = 0;
  endtask

  typedef struct {
    bit iv, inv, dv;
    bit ei, ed;
  } gvec_t;
  gvec_t gtab[8];

  // Reference model state (transaction level)
  bit            m_active, m_acc, m_own_i, m_drop, m_we;
  int            m_starve;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  int            rsp_delay;
  bit            pend_i, pend_d;

  initial begin
    bit gi;
    bit exp_seq[6];

    // Grant table, evaluated from IDLE with starvation count at zero
    gtab[0] = '{0,0,0, 0,0}; gtab[1] = '{0,0,1, 0,1};
    gtab[2] = '{0,1,0, 0,0}; gtab[3] = '{0,1,1, 0,1};
    gtab[4] = '{1,0,0, 1,0}; gtab[5] = '{1,0,1, 0,1};
    gtab[6] = '{1,1,0, 0,0}; gtab[7] = '{1,1,1, 0,1};
    for (int k = 0; k < 8; k++) begin
      do_reset();
      i_req_valid = gtab[k].iv; invalidate_fetch = gtab[k].inv; d_req_valid = gtab[k].dv;
      i_req_addr = 32'h40 + k; d_req_addr = 32'h80 + k;
      @(negedge clk);
      chk($sformatf("gtab%0d_i_ready", k), i_req_ready, gtab[k].ei);
      chk($sformatf("gtab%0d_d_ready", k), d_req_ready, gtab[k].ed);
      chk($sformatf("gtab%0d_busy", k), busy, 0);
    end

    // 1: fetch only, latency and response
    do_reset();
    @(negedge clk);
    chk("rst_outputs", {i_req_ready, d_req_ready, mem_req_valid, i_rsp_valid, d_rsp_valid, busy}, 0);
    chk("rst_fields", {mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_req_we}, 0);
    next_cycle();
    i_req_valid = 1; i_req_addr = 32'h100;
    @(negedge clk);
    chk("t1_i_ready_N", i_req_ready, 1);
    chk("t1_mem_valid_N", mem_req_valid, 0);
    next_cycle();
    i_req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    chk("t1_mem_valid_N1", mem_req_valid, 1);
    chk("t1_mem_fields", {mem_req_addr, mem_req_we, mem_req_wstrb}, {32'h100, 1'b0, 4'h0});
    chk("t1_i_ready_N1", i_req_ready, 0);
    next_cycle();
    mem_req_ready = 0;
    @(negedge clk);
    chk("t1_mem_valid_wait", mem_req_valid, 0);
    chk("t1_busy_wait", busy, 1);
    next_cycle();
    mem_rsp_valid = 1; mem_rsp_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_i_rsp", {i_rsp_valid, i_rsp_data}, {1'b1, 32'hDEADBEEF});
    next_cycle();
    mem_rsp_valid = 0; mem_rsp_data = '0;
    @(negedge clk);
    chk("t1_after", {busy, i_rsp_valid, i_rsp_data}, 0);

    // 2: simultaneous requests, data store first then fetch
    do_reset();
    i_req_valid = 1; i_req_addr = 32'h104;
    d_req_valid = 1; d_req_addr = 32'h200; d_req_we = 1; d_req_wdata = 32'h12345678; d_req_wstrb = 4'hF;
    @(negedge clk);
    chk("t2_d_first", {i_req_ready, d_req_ready}, 2'b01);
    next_cycle();
    d_req_valid = 0; d_req_we = 0;
    @(negedge clk);
    chk("t2_mem_fields", {mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb},
        {1'b1, 32'h200, 1'b1, 32'h12345678, 4'hF});
    mem_req_ready = 1;
    next_cycle();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0BAD0BAD;
    @(negedge clk);
    chk("t2_d_rsp", {d_rsp_valid, i_rsp_valid}, 2'b10);
    next_cycle();
    mem_rsp_valid = 0;
    @(negedge clk);
    chk("t2_i_next", {i_req_ready, d_req_ready}, 2'b10);
    next_cycle();
    i_req_valid = 0;
    serve_txn(1, 32'h55667788);

    // 3: starvation guard with both requesters always asking
    do_reset();
    exp_seq = '{0, 0, 0, 0, 1, 0};
    i_req_valid = 1; i_req_addr = 32'h300; d_req_valid = 1; d_req_addr = 32'h340;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      gi = i_req_ready;
      chk($sformatf("t3_onehot%0d", g), i_req_ready ^ d_req_ready, 1);
      chk($sformatf("t3_grant%0d_is_i", g), gi, exp_seq[g]);
      serve_txn(gi, 32'hC0DE0000 + g);
    end
    clear_inputs();

    // 4: invalidate while fetch waits; response swallowed, next fetch normal
    do_reset();
    i_req_valid = 1; i_req_addr = 32'h400;
    @(negedge clk);
    chk("t4_i_ready", i_req_ready, 1);
    next_cycle();
    i_req_valid = 0; mem_req_ready = 1;
    next_cycle();
    mem_req_ready = 0; invalidate_fetch = 1;
    next_cycle();
    invalidate_fetch = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hAAAA5555;
    @(negedge clk);
    chk("t4_dropped", {i_rsp_valid, i_rsp_data, d_rsp_valid}, 0);
    next_cycle();
    mem_rsp_valid = 0;
    @(negedge clk);
    chk("t4_idle", busy, 0);
    next_cycle();
    i_req_valid = 1; i_req_addr = 32'h404;
    @(negedge clk);
    chk("t4_refetch_ready", i_req_ready, 1);
    next_cycle();
    i_req_valid = 0;
    serve_txn(1, 32'h13579BDF);

    // 5: downstream stall with changing inputs
    do_reset();
    d_req_valid = 1; d_req_addr = 32'h500; d_req_we = 0; d_req_wstrb = 4'h3;
    @(negedge clk);
    chk("t5_d_ready", d_req_ready, 1);
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      i_req_valid = 1; i_req_addr = $urandom; d_req_valid = 1; d_req_addr = $urandom;
      d_req_we = 1; d_req_wdata = $urandom; d_req_wstrb = 4'hF;
      @(negedge clk);
      chk($sformatf("t5_stable%0d", c), {mem_req_valid, mem_req_addr, mem_req_we, mem_req_wstrb},
          {1'b1, 32'h500, 1'b0, 4'h3});
      chk($sformatf("t5_no_ready%0d", c), {i_req_ready, d_req_ready}, 0);
    end
    next_cycle();
    clear_inputs();
    mem_req_ready = 1;
    next_cycle();
    mem_req_ready = 0;
    next_cycle();
    mem_rsp_valid = 1; mem_rsp_data = 32'h77;
    @(negedge clk);
    chk("t5_rsp", {d_rsp_valid, d_rsp_data}, {1'b1, 32'h77});
    next_cycle();
    mem_rsp_valid = 0;

    // 6: reset asserted in WAIT
    do_reset();
    d_req_valid = 1; d_req_addr = 32'h600;
    @(negedge clk);
    chk("t6_d_ready", d_req_ready, 1);
    next_cycle();
    mem_req_ready = 1;
    next_cycle();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h66;
    rst = 1;
    #1;
    chk("t6_rst_same_cycle", {mem_req_valid, i_rsp_valid, d_rsp_valid, busy}, 0);
    @(posedge clk);
    #1 rst = 0; mem_rsp_valid = 0;
    @(negedge clk);
    chk("t6_fresh_grant", d_req_ready, 1);
    next_cycle();
    d_req_valid = 0;
    serve_txn(0, 32'h99);

    // Randomized run against the reference model
    do_reset();
    m_active = 0; m_acc = 0; m_starve = 0; m_drop = 0; m_own_i = 0;
    pend_i = 0; pend_d = 0; rsp_delay = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit ei, ed, exp_irsp, exp_drsp;
      if (pend_i && $urandom_range(0, 15) == 0) pend_i = 0;
      else if (!pend_i && $urandom_range(0, 1) == 1) begin
        pend_i = 1; i_req_addr = $urandom;
      end
      if (pend_d && $urandom_range(0, 15) == 0) pend_d = 0;
      else if (!pend_d && $urandom_range(0, 2) != 0) begin
        pend_d = 1; d_req_addr = $urandom; d_req_we = 1'($urandom);
        d_req_wdata = $urandom; d_req_wstrb = 4'($urandom);
      end
      i_req_valid = pend_i; d_req_valid = pend_d;
      invalidate_fetch = ($urandom_range(0, 7) == 0);
      mem_req_ready = ($urandom_range(0, 2) != 0);
      mem_rsp_data = $urandom;
      mem_rsp_valid = 0;
      if (m_active && m_acc) begin
        if (rsp_delay == 0) mem_rsp_valid = 1;
        else rsp_delay--;
      end

      @(negedge clk);
      ei = 0; ed = 0; exp_irsp = 0; exp_drsp = 0;
      if (!m_active) begin
        ei = i_req_valid && !invalidate_fetch && (m_starve == LIM || !d_req_valid);
        ed = !ei && d_req_valid;
      end else if (m_acc && mem_rsp_valid) begin
        exp_irsp = m_own_i && !m_drop;
        exp_drsp = !m_own_i;
      end
      chk("rnd_ready", {i_req_ready, d_req_ready}, {ei, ed});
      chk("rnd_busy", busy, m_active);
      chk("rnd_mem_valid", mem_req_valid, m_active && !m_acc);
      if (m_active && !m_acc)
        chk("rnd_mem_fields", {mem_req_addr, mem_req_we, mem_req_wstrb, m_we ? mem_req_wdata : 32'h0},
            {m_addr, m_we, m_wstrb, m_we ? m_wdata : 32'h0});
      chk("rnd_i_rsp", {i_rsp_valid, i_rsp_data}, {exp_irsp, exp_irsp ? mem_rsp_data : 32'h0});
      chk("rnd_d_rsp", {d_rsp_valid, d_rsp_data}, {exp_drsp, exp_drsp ? mem_rsp_data : 32'h0});

      if (!m_active) begin
        if (ei) begin
          m_active = 1; m_acc = 0; m_own_i = 1; m_drop = 0; m_starve = 0;
          m_addr = i_req_addr; m_we = 0; m_wdata = '0; m_wstrb = '0; pend_i = 0;
        end else if (ed) begin
          m_active = 1; m_acc = 0; m_own_i = 0; m_drop = 0;
          if (i_req_valid && m_starve < LIM) m_starve++;
          m_addr = d_req_addr; m_we = d_req_we; m_wdata = d_req_wdata; m_wstrb = d_req_wstrb;
          pend_d = 0;
        end
      end else begin
        if (m_own_i && invalidate_fetch) m_drop = 1;
        if (!m_acc) begin
          if (mem_req_ready) begin
            m_acc = 1; rsp_delay = $urandom_range(0, 3);
          end
        end else if (mem_rsp_valid) m_active = 0;
      end
      next_cycle();
    end
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
